countdown_timer: RTL and testbench

//  Loadable down-counting timer: counts a loaded value N down to zero and emits a
//  one-cycle terminal pulse. Complements the up-counting intCounter; used for

---
 rtl/countdown_timer_pkg.sv | 14 +
 rtl/tick_prescaler.sv | 40 ++++
 rtl/countdown_timer.sv | 108 ++++++++++
 tb/tb_countdown_timer.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/countdown_timer_pkg.sv
// Shared types and helpers for the loadable down-counting timer.
// Holds the FSM state encoding and the count-width function.
package countdown_timer_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    function automatic int cdt_width(input int max_count);
        return $clog2(max_count + 1);
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Divides the clock into one count tick every PRESCALE cycles while running.
// Only built when COUNTDOWN_TIMER_PRESCALER_EN is defined.
`ifdef COUNTDOWN_TIMER_PRESCALER_EN
module tick_prescaler #(
    parameter int PRESCALE = 1
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic run,
    output logic tick
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

    logic [PW-1:0] cnt_q;
    logic [PW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (run) begin
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + PW'(1);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = run && (cnt_q == LAST);

endmodule
`endif

// File: rtl/countdown_timer.sv
// Loadable down-counter with one-shot/auto-reload modes, abort and a registered terminal pulse.
// Define COUNTDOWN_TIMER_PRESCALER_EN to count one step every PRESCALE clocks instead of every clock.
//
// state | meaning
// IDLE  | not counting, dout holds last value
// RUN   | counting down once per tick
module countdown_timer
    import countdown_timer_pkg::*;
#(
    parameter  int MAX      = 20,
    parameter  int PRESCALE = 1,
    localparam int W        = cdt_width(MAX)
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         start,
    input  logic         stop,
    input  logic         reload_mode,
    input  logic [W-1:0] din,
    output logic         busy,
    output logic         zero_pulse,
    output logic [W-1:0] dout
);

    if (PRESCALE < 1) begin : g_prescale_invalid
        $error("countdown_timer: PRESCALE must be >= 1");
    end

    state_t         state_q, state_d;
    logic [W-1:0]   dout_q, dout_d;
    logic [W-1:0]   reload_q, reload_d;
    logic           mode_q, mode_d;
    logic           pulse_q, pulse_d;
    logic           tick;

`ifdef COUNTDOWN_TIMER_PRESCALER_EN
    tick_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_tick_prescaler (
        .clock (clock),
        .reset (reset),
        .clear (start || stop || (state_d == IDLE)),
        .run   (state_q == RUN),
        .tick  (tick)
    );
`else
    assign tick = 1'b1;
`endif

    always_comb begin
        state_d  = state_q;
        dout_d   = dout_q;
        reload_d = reload_q;
        mode_d   = mode_q;
        pulse_d  = 1'b0;

        // A start with din == 0 completes immediately; shared by IDLE and RUN restart.
        if ((state_q == IDLE && start) || (state_q == RUN && start && !stop)) begin
            if (din != '0) begin
                state_d  = RUN;
                dout_d   = din;
                reload_d = din;
                mode_d   = reload_mode;
            end else begin
                state_d  = IDLE;
                dout_d   = '0;
                pulse_d  = 1'b1;
            end
        end else if (state_q == RUN) begin
            if (stop) begin
                state_d = IDLE;
            end else if (tick) begin
                if (dout_q > W'(1)) begin
                    dout_d = dout_q - W'(1);
                end else begin
                    pulse_d = 1'b1;
                    if (mode_q) begin
                        dout_d = reload_q;
                    end else begin
                        dout_d  = '0;
                        state_d = IDLE;
                    end
                end
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            dout_q   <= '0;
            reload_q <= '0;
            mode_q   <= 1'b0;
            pulse_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            dout_q   <= dout_d;
            reload_q <= reload_d;
            mode_q   <= mode_d;
            pulse_q  <= pulse_d;
        end
    end

    assign busy       = (state_q == RUN);
    assign zero_pulse = pulse_q;
    assign dout       = dout_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Scoreboard bench for countdown_timer: directed scenarios then random traffic against a reference model.
module tb_countdown_timer;

    localparam int MAX = 20;
`ifdef COUNTDOWN_TIMER_PRESCALER_EN
    localparam int PRESCALE = 4;
`else
    localparam int PRESCALE = 1;
`endif
    localparam int W = $clog2(MAX + 1);

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic         stop = 1'b0;
    logic         reload_mode = 1'b0;
    logic [W-1:0] din = '0;
    logic         busy;
    logic         zero_pulse;
    logic [W-1:0] dout;

    countdown_timer #(
        .MAX      (MAX),
        .PRESCALE (PRESCALE)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .stop        (stop),
        .reload_mode (reload_mode),
        .din         (din),
        .busy        (busy),
        .zero_pulse  (zero_pulse),
        .dout        (dout)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic         busy;
        logic         pulse;
        logic [W-1:0] dout;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    // Reference model: remaining count, running flag, latched mode/reload, tick phase.
    bit   m_run;
    int   m_cnt;
    bit   m_mode;
    int   m_reload;
    int   m_phase;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
        end
    endtask

    task automatic model_reset();
        m_run    = 1'b0;
        m_cnt    = 0;
        m_mode   = 1'b0;
        m_reload = 0;
        m_phase  = 0;
    endtask

    task automatic step(input bit s, input bit p, input bit rm, input int d);
        bit   ticked;
        bit   pulse;
        bit   was_run;
        exp_t e;
        @(negedge clock);
        #1;
        reset       = 1'b0;
        start       = s;
        stop        = p;
        reload_mode = rm;
        din         = W'(d);

        was_run = m_run;
        ticked  = m_run && (m_phase == PRESCALE - 1);
        pulse   = 1'b0;
        if (m_run && p) begin
            m_run = 1'b0;
        end else if (s) begin
            if (d != 0) begin
                m_run = 1'b1; m_cnt = d; m_mode = rm; m_reload = d;
            end else begin
                m_run = 1'b0; m_cnt = 0; pulse = 1'b1;
            end
        end else if (ticked) begin
            if (m_cnt > 1) begin
                m_cnt = m_cnt - 1;
            end else begin
                pulse = 1'b1;
                if (m_mode) m_cnt = m_reload;
                else begin m_cnt = 0; m_run = 1'b0; end
            end
        end
        if (s || p || !m_run) m_phase = 0;
        else if (was_run) m_phase = (m_phase + 1) % PRESCALE;

        e.busy  = m_run;
        e.pulse = pulse;
        e.dout  = W'(m_cnt);
        exp_q.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 0);
    endtask

    // Monitor: the DUT presents a result every cycle; compare away from the active edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("busy",       int'(busy),       int'(e.busy));
                chk("zero_pulse", int'(zero_pulse), int'(e.pulse));
                chk("dout",       int'(dout),       int'(e.dout));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int guard;
        model_reset();
        #3;
        chk("reset_dout",  int'(dout),       0);
        chk("reset_busy",  int'(busy),       0);
        chk("reset_pulse", int'(zero_pulse), 0);

        // One-shot N=5
        step(1'b1, 1'b0, 1'b0, 5);
        idle(6 * PRESCALE + 2);

        // Auto-reload N=3, then abort
        step(1'b1, 1'b0, 1'b1, 3);
        idle(10 * PRESCALE);
        step(1'b0, 1'b1, 1'b0, 0);
        idle(2);

        // Auto-reload N=1 pulses every tick
        step(1'b1, 1'b0, 1'b1, 1);
        idle(4 * PRESCALE);
        step(1'b0, 1'b1, 1'b0, 0);

        // din = 0 and din = MAX
        step(1'b1, 1'b0, 1'b0, 0);
        idle(2);
        step(1'b1, 1'b0, 1'b0, MAX);
        idle(MAX * PRESCALE + 3);

        // start + stop together while running: stop wins
        step(1'b1, 1'b0, 1'b1, 6);
        idle(2 * PRESCALE);
        step(1'b1, 1'b1, 1'b1, 9);
        idle(3);

        // restart mid-count with din = 7
        step(1'b1, 1'b0, 1'b0, 4);
        idle(PRESCALE);
        step(1'b1, 1'b0, 1'b0, 7);
        idle(8 * PRESCALE + 2);

        // Asynchronous reset while dout == 2
        step(1'b1, 1'b0, 1'b0, 9);
        guard = 0;
        while (m_cnt != 2 && guard < 100 * PRESCALE) begin
            idle(1);
            guard++;
        end
        chk("reach_dout2_bound", int'(m_cnt == 2), 1);
        @(posedge clock);
        #1;
        chk("pre_reset_dout", int'(dout), 2);
        #1;
        reset = 1'b1;
        exp_q.delete();
        model_reset();
        #1;
        chk("async_reset_dout",  int'(dout),       0);
        chk("async_reset_busy",  int'(busy),       0);
        chk("async_reset_pulse", int'(zero_pulse), 0);
        @(negedge clock);
        @(negedge clock);
        idle(4);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 7) == 0,
                 $urandom_range(0, 15) == 0,
                 1'($urandom_range(0, 1)),
                 int'($urandom_range(0, MAX)));
        end
        idle(3);
        @(negedge clock);
        @(negedge clock);
        #1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
